// File: rtl/exec_sequencer.sv
// exec_sequencer: four-phase instruction sequencer (IDLE -> READ -> EXEC -> WB).
// Accepts one ALU instruction at a time and latches its fields. It reads two
// source registers from an external bank and drives an external combinational
// ALU. It then writes the result back to the destination register. R0 and
// reserved opcodes never produce a write.
module exec_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_opcode,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [REG_AW-1:0] instr_rd,
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic accept;

  // Instruction fields, latched on acceptance
  logic [3:0]        opcode_p0;
  logic [REG_AW-1:0] rs1_p0;
  logic [REG_AW-1:0] rs2_p0;
  logic [REG_AW-1:0] rd_p0;

  // Operands captured at the end of READ
  logic [DATA_W-1:0] op_a_p1;
  logic [DATA_W-1:0] op_b_p1;

  // ALU result captured at the end of EXEC
  logic [DATA_W-1:0] res_p2;

  // Opcodes with bit 3 set are reserved and execute as a NOP.
  function automatic logic is_reserved(input logic [3:0] op);
    return op[3];
  endfunction

  // A writeback commits only for a real opcode targeting a writable register.
  function automatic logic commit_allowed(input logic [REG_AW-1:0] rd,
                                          input logic [3:0]        op);
    return (rd != '0) && !is_reserved(op);
  endfunction

  // Handshake: accept only in IDLE and never while reset is asserted
  always_comb begin
    accept = (state_q == S_IDLE) && rst_n && instr_valid;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only IDLE waits; every other phase lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p0: latch instruction fields on acceptance ----
  // Fields are latched only here; instr_valid outside IDLE is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_p0 <= '0;
      rs1_p0    <= '0;
      rs2_p0    <= '0;
      rd_p0     <= '0;
    end else if (accept) begin
      opcode_p0 <= instr_opcode;
      rs1_p0    <= instr_rs1;
      rs2_p0    <= instr_rs2;
      rd_p0     <= instr_rd;
    end
  end

  // ---- stage p1: register bank read data captured on the READ->EXEC edge ----
  // Capture operands from the bank while the latched addresses are stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_p1 <= '0;
      op_b_p1 <= '0;
    end else if (state_q == S_READ) begin
      op_a_p1 <= rf_data1;
      op_b_p1 <= rf_data2;
    end
  end

  // ---- stage p2: ALU result captured on the EXEC->WB edge ----
  // Store the ALU output unmodified; wrap/borrow semantics belong to the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p2 <= '0;
    end else if (state_q == S_EXEC) begin
      res_p2 <= alu_result;
    end
  end

  // Outputs are decoded from state and latched values only, never instr_*
  always_comb begin
    instr_ready     = (state_q == S_IDLE) && rst_n;
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_WB);
    rf_read_reg1    = rs1_p0;
    rf_read_reg2    = rs2_p0;
    alu_a           = op_a_p1;
    alu_b           = op_b_p1;
    alu_opcode      = opcode_p0;
    rf_write_reg    = rd_p0;
    rf_write_data   = res_p2;
    rf_write_enable = (state_q == S_WB) && commit_allowed(rd_p0, opcode_p0);
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: drives directed and randomized instructions into
// exec_sequencer. The bench provides a register bank and an ALU around the
// DUT, and compares the results against an architectural register-file model.
module tb_exec_sequencer;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_opcode;
  logic [REG_AW-1:0] instr_rs1;
  logic [REG_AW-1:0] instr_rs2;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] rf_read_reg1;
  logic [REG_AW-1:0] rf_read_reg2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic [REG_AW-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_enable;
  logic              busy;
  logic              done;

  int checks = 0;
  int passes = 0;

  logic [DATA_W-1:0] tb_rf  [16];
  logic [DATA_W-1:0] ref_rf [16];
  logic              pl_en;
  logic [3:0]        pl_addr;
  logic [DATA_W-1:0] pl_data;

  always #5 clk = ~clk;

  exec_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .busy(busy), .done(done)
  );

  // Environment ALU: defined operations for 0-7, arbitrary value for reserved codes
  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);
  assign rf_data1   = tb_rf[rf_read_reg1];
  assign rf_data2   = tb_rf[rf_read_reg2];

  // Register bank: DUT write port, plus a preload port used only during reset
  always @(posedge clk) begin
    if (rf_write_enable) tb_rf[rf_write_reg] <= rf_write_data;
    else if (pl_en)      tb_rf[pl_addr]      <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Issue one instruction starting just after a falling edge and follow it to IDLE.
  // With hold set, instr_valid stays high and the next instruction's fields are
  // offered while this one is in flight.
  task automatic do_instr(input logic [3:0] op, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [3:0] rd,
                          input bit hold, input logic [3:0] nop,
                          input logic [3:0] nrs1, input logic [3:0] nrs2,
                          input logic [3:0] nrd, output int waited);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp;
    logic              we_exp;
    waited = 0;
    while (instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (instr_ready !== 1'b1) begin
      chk1("ready_timeout", instr_ready, 1'b1);
      return;
    end
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_rs1    = rs1;
    instr_rs2    = rs2;
    instr_rd     = rd;
    a      = ref_rf[rs1];
    b      = ref_rf[rs2];
    exp    = alu_f(op, a, b);
    we_exp = (rd != 4'd0) && !op[3];
    @(posedge clk);
    #1;
    if (hold) begin
      instr_opcode = nop;
      instr_rs1    = nrs1;
      instr_rs2    = nrs2;
      instr_rd     = nrd;
    end else begin
      instr_valid  = 1'b0;
      instr_opcode = 4'($urandom_range(0, 15));
      instr_rs1    = 4'($urandom_range(0, 15));
      instr_rs2    = 4'($urandom_range(0, 15));
      instr_rd     = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    chk1("read_busy", busy, 1'b1);
    chk1("read_ready", instr_ready, 1'b0);
    chk1("read_done", done, 1'b0);
    chk1("read_we", rf_write_enable, 1'b0);
    chk("read_reg1", 32'(rf_read_reg1), 32'(rs1));
    chk("read_reg2", 32'(rf_read_reg2), 32'(rs2));
    @(negedge clk);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_op", 32'(alu_opcode), 32'(op));
    chk1("exec_done", done, 1'b0);
    chk1("exec_we", rf_write_enable, 1'b0);
    @(negedge clk);
    chk1("wb_done", done, 1'b1);
    chk1("wb_busy", busy, 1'b1);
    chk1("wb_we", rf_write_enable, we_exp);
    if (we_exp) begin
      chk("wb_reg", 32'(rf_write_reg), 32'(rd));
      chk("wb_data", rf_write_data, exp);
      ref_rf[rd] = exp;
    end
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ready", instr_ready, 1'b1);
    chk1("idle_done", done, 1'b0);
    chk1("idle_we", rf_write_enable, 1'b0);
    chk("rf_dest", tb_rf[rd], ref_rf[rd]);
    chk("rf_r0", tb_rf[0], 32'd0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    bit         hold;
  } instr_t;

  instr_t rnd [41];
  int     w;

  initial begin
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = 4'd0;
    instr_rs1    = 4'd0;
    instr_rs2    = 4'd0;
    instr_rd     = 4'd0;
    pl_en        = 1'b0;
    pl_addr      = 4'd0;
    pl_data      = '0;

    // Preload the bank while reset is held
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 4'(i);
      if (i == 1)      pl_data = 32'd5;
      else if (i == 2) pl_data = 32'd3;
      else if (i >= 9) pl_data = $urandom;
      else             pl_data = 32'd0;
      ref_rf[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    chk1("rst_ready", instr_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_we", rf_write_enable, 1'b0);
    chk("rst_rd_addr", 32'(rf_read_reg1), 32'd0);
    chk("rst_wr_data", rf_write_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);

    rst_n = 1'b1;
    #1;
    chk1("post_rst_ready", instr_ready, 1'b1);
    @(negedge clk);

    // ADD R3 = R1 + R2
    do_instr(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, w);
    chk("add_r3", tb_rf[3], 32'd8);

    // SUB then AND back to back with instr_valid held high
    do_instr(4'd1, 4'd1, 4'd2, 4'd4, 1'b1, 4'd2, 4'd1, 4'd2, 4'd5, w);
    do_instr(4'd2, 4'd1, 4'd2, 4'd5, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, w);
    chk("b2b_wait", 32'(w), 32'd0);
    chk("sub_r4", tb_rf[4], 32'd2);
    chk("and_r5", tb_rf[5], 32'd1);

    // Destination R0 is read-only
    do_instr(4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, w);
    chk("r0_kept", tb_rf[0], 32'd0);

    // Reserved opcode is a NOP
    do_instr(4'b1010, 4'd1, 4'd2, 4'd6, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, w);
    chk("nop_r6", tb_rf[6], 32'd0);

    // Reset during EXEC discards the instruction
    instr_valid  = 1'b1;
    instr_opcode = 4'd0;
    instr_rs1    = 4'd1;
    instr_rs2    = 4'd2;
    instr_rd     = 4'd7;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    chk1("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_we", rf_write_enable, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_ready", instr_ready, 1'b0);
    chk("mid_rst_wreg", 32'(rf_write_reg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("post_rst_we", rf_write_enable, 1'b0);
      chk1("post_rst_idle", busy, 1'b0);
    end
    chk("r7_kept", tb_rf[7], 32'd0);

    // Dependent pair: second instruction reads the register the first wrote
    do_instr(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, w);
    do_instr(4'd0, 4'd3, 4'd1, 4'd8, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, w);
    chk("raw_r8", tb_rf[8], 32'd13);

    // Randomized instruction stream, sometimes issued back to back
    for (int i = 0; i < 41; i++) begin
      rnd[i].op   = 4'($urandom_range(0, 15));
      rnd[i].rs1  = 4'($urandom_range(0, 15));
      rnd[i].rs2  = 4'($urandom_range(0, 15));
      rnd[i].rd   = 4'($urandom_range(0, 15));
      rnd[i].hold = ($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 40; i++) begin
      do_instr(rnd[i].op, rnd[i].rs1, rnd[i].rs2, rnd[i].rd,
               (i < 39) && rnd[i].hold,
               rnd[i+1].op, rnd[i+1].rs1, rnd[i+1].rs2, rnd[i+1].rd, w);
    end
    for (int i = 0; i < 16; i++) begin
      chk("final_rf", tb_rf[i], ref_rf[i]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
